toggle_job_arbiter: RTL and testbench

Round-robin scheduler that shares one periodic toggle engine (programmable-period counter driving a `status` toggle) between `NREQ` requesters. Each requester submits a job of a toggle period and a toggle count. The block grants the engine to one requester at a time, runs the job, and reports completion with a per-requester done pulse. It sits between the control clients and the single `status` output.

---
 rtl/toggle_job_arbiter.sv | 134 +++++++++++++
 tb/tb_toggle_job_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_job_arbiter.sv
// Round-robin arbiter that shares one periodic toggle engine between NREQ requesters.
// A granted job toggles status N times, one toggle every P+1 cycles, then pulses done.
module toggle_job_arbiter #(
  parameter int NREQ = 4,
  parameter int CW   = 8,
  parameter int NW   = 8,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*CW-1:0]   req_period,
  input  logic [NREQ*NW-1:0]   req_count,
  input  logic                 abort,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      done,
  output logic                 status,
  output logic                 busy,
  output logic [IDW-1:0]       owner,
  output logic [1:0]           state_dbg
);

  // Handshake: a requester holds req and its period/count slices stable until its
  // one-cycle ack pulse, then drops req; dropping req before ack withdraws the request.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  last_q, last_d, owner_d;
  logic [CW-1:0]   period_q, period_d, cnt_q, cnt_d;
  logic [NW-1:0]   rem_q, rem_d;
  logic [NREQ-1:0] ack_d, done_d;
  logic            status_d, busy_d;
  logic            grant_found;
  logic [IDW-1:0]  grant_idx, cand_idx;

  assign state_dbg = state_q;

  // First pending request after the last grant, wrapping at NREQ.
  always_comb begin : rr_search
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_idx = IDW'((int'(last_q) + k) % NREQ);
      if (!grant_found && req[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_comb begin : next_state_logic
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner;
    period_d = period_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    ack_d    = '0;
    done_d   = '0;
    status_d = status;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          owner_d         = grant_idx;
          last_d          = grant_idx;
          period_d        = req_period[grant_idx*CW +: CW];
          rem_d           = req_count[grant_idx*NW +: NW];
          cnt_d           = '0;
          ack_d[grant_idx] = 1'b1;
          state_d         = (rem_d == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d  = IDLE;
          status_d = 1'b0;
        end else if (cnt_q == period_q) begin
          cnt_d    = '0;
          status_d = ~status;
          rem_d    = rem_q - 1'b1;
          if (rem_q == NW'(1)) begin
            state_d        = DONE;
            done_d[owner]  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        // A zero-count job enters DONE with ack still high; its done pulse follows.
        if (ack != '0) begin
          done_d[owner] = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= IDW'(NREQ - 1);
      owner    <= '0;
      period_q <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      ack      <= '0;
      done     <= '0;
      status   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner    <= owner_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      ack      <= ack_d;
      done     <= done_d;
      status   <= status_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_toggle_job_arbiter.sv
// Self-checking bench for toggle_job_arbiter: directed scenarios plus random jobs,
// all checked against a cycle-offset model of each job derived from the job rules.
module tb_toggle_job_arbiter;
  localparam int NREQ = 4;
  localparam int CW   = 8;
  localparam int NW   = 8;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*CW-1:0]  req_period = '0;
  logic [NREQ*NW-1:0]  req_count = '0;
  logic                abort = 1'b0;
  logic [NREQ-1:0]     ack, done;
  logic                status, busy;
  logic [IDW-1:0]      owner;
  logic [1:0]          state_dbg;

  int checks = 0;
  int passes = 0;
  bit m_stat;
  int m_last;

  logic [NREQ-1:0] e_ack, e_done;
  logic            e_busy, e_status;
  logic [IDW-1:0]  e_owner;

  always #5 clk = ~clk;

  toggle_job_arbiter #(.NREQ(NREQ), .CW(CW), .NW(NW), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_period(req_period), .req_count(req_count),
    .abort(abort), .ack(ack), .done(done), .status(status), .busy(busy), .owner(owner),
    .state_dbg(state_dbg)
  );

  // Round-robin rule: first set bit after last, wrapping.
  function automatic int rr_pick(input int last, input logic [NREQ-1:0] mask);
    for (int k = 1; k <= NREQ; k++) begin
      if (mask[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  // Expected outputs c cycles after the grant edge (c=0 is the first cycle after it).
  // ab is the cycle during which abort is held high, or -1 for none.
  task automatic job_model(input int c, input int idx, input int p, input int n,
                           input int ab, input bit init);
    int done_c;
    int tog;
    done_c   = (n == 0) ? 1 : n * (p + 1);
    e_ack    = '0;
    e_done   = '0;
    e_busy   = 1'b0;
    e_status = 1'b0;
    e_owner  = IDW'(idx);
    if (ab >= 0 && c > ab) return;
    tog = c / (p + 1);
    if (tog > n) tog = n;
    if (c == 0) e_ack[idx] = 1'b1;
    if (c == done_c) e_done[idx] = 1'b1;
    e_busy   = (c <= done_c);
    e_status = init ^ tog[0];
  endtask

  task automatic set_job(input int idx, input int p, input int n);
    req_period[idx*CW +: CW] = CW'(p);
    req_count[idx*NW +: NW]  = NW'(n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_stat = 1'b0;
    m_last = NREQ - 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = '0;
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if ({ack, done, busy, status, owner} !== '0)
      $display("FAIL reset_held got %b exp 0", {ack, done, busy, status, owner});
    else passes++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ack, done, busy, status, owner} !== '0)
      $display("FAIL reset_idle got %b exp 0", {ack, done, busy, status, owner});
    else passes++;
    m_stat = 1'b0;
    m_last = NREQ - 1;
  endtask

  task automatic test_single_job();
    set_job(1, 2, 3);
    req = 4'b0010;
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk);
      job_model(c, 1, 2, 3, -1, m_stat);
      if (c == 0) req = '0;
      checks++;
      if ({ack, done, busy, status, owner} !== {e_ack, e_done, e_busy, e_status, e_owner})
        $display("FAIL single c=%0d got %b exp %b", c, {ack, done, busy, status, owner},
                 {e_ack, e_done, e_busy, e_status, e_owner});
      else passes++;
    end
    m_stat = ~m_stat;
    m_last = 1;
  endtask

  task automatic test_fairness();
    int ack_idx[$], ack_cyc[$], done_idx[$], done_cyc[$];
    int exp_idx;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_job(i, 0, 1);
    req = '1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      for (int b = 0; b < NREQ; b++) begin
        if (ack[b])  begin ack_idx.push_back(b);  ack_cyc.push_back(cyc);  end
        if (done[b]) begin done_idx.push_back(b); done_cyc.push_back(cyc); end
      end
      if (ack_idx.size() == 5) begin
        req = '0;
        break;
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (ack_idx.size() != 5) $display("FAIL fair_count got %0d exp 5", ack_idx.size());
    else passes++;
    exp_idx = m_last;
    for (int i = 0; i < ack_idx.size(); i++) begin
      exp_idx = rr_pick(exp_idx, 4'hF);
      checks++;
      if (ack_idx[i] != exp_idx) $display("FAIL fair_order i=%0d got %0d exp %0d", i, ack_idx[i], exp_idx);
      else passes++;
    end
    for (int i = 0; i < 4 && i < done_cyc.size() && i + 1 < ack_cyc.size(); i++) begin
      checks++;
      if (ack_cyc[i+1] != done_cyc[i] + 2 || done_idx[i] != ack_idx[i])
        $display("FAIL fair_gap i=%0d got ack@%0d done%0d@%0d exp ack@%0d done%0d",
                 i, ack_cyc[i+1], done_idx[i], done_cyc[i], done_cyc[i] + 2, ack_idx[i]);
      else passes++;
    end
    m_stat = 1'b1;
    m_last = 0;
  endtask

  task automatic test_wrap();
    logic [NREQ-1:0] t_ack [0:8];
    logic [NREQ-1:0] t_done[0:8];
    logic [IDW-1:0]  t_own [0:8];
    t_ack  = '{4'b1000, 0, 0, 4'b0010, 0, 0, 4'b0100, 0, 0};
    t_done = '{0, 4'b1000, 0, 0, 4'b0010, 0, 0, 4'b0100, 0};
    t_own  = '{2'd3, 2'd3, 2'd3, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
    for (int i = 0; i < NREQ; i++) set_job(i, 0, 1);
    req = 4'b1000;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      if (c == 0) req = 4'b0110;
      if (c == 3) req = 4'b0100;
      if (c == 6) req = '0;
      checks++;
      if ({ack, done, owner} !== {t_ack[c], t_done[c], t_own[c]})
        $display("FAIL wrap c=%0d got %b exp %b", c, {ack, done, owner}, {t_ack[c], t_done[c], t_own[c]});
      else passes++;
    end
    m_stat = ~m_stat;
    m_last = 2;
  endtask

  task automatic test_abort();
    set_job(0, 4, 10);
    set_job(1, 0, 1);
    req = 4'b0001;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      if (c <= 7) job_model(c, 0, 4, 10, 6, m_stat);
      else job_model(c - 8, 1, 0, 1, -1, 1'b0);
      if (c == 0) req = 4'b0010;
      if (c == 8) req = '0;
      checks++;
      if ({ack, done, busy, status, owner} !== {e_ack, e_done, e_busy, e_status, e_owner})
        $display("FAIL abort c=%0d got %b exp %b", c, {ack, done, busy, status, owner},
                 {e_ack, e_done, e_busy, e_status, e_owner});
      else passes++;
      abort = (c == 6);
    end
    m_stat = 1'b1;
    m_last = 1;
  endtask

  task automatic test_zero_count();
    set_job(2, 7, 0);
    req = 4'b0100;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      job_model(c, 2, 7, 0, -1, m_stat);
      if (c == 0) req = '0;
      checks++;
      if ({ack, done, busy, status, owner} !== {e_ack, e_done, e_busy, e_status, e_owner})
        $display("FAIL zero_count c=%0d got %b exp %b", c, {ack, done, busy, status, owner},
                 {e_ack, e_done, e_busy, e_status, e_owner});
      else passes++;
      abort = (c == 0);
    end
    m_last = 2;
  endtask

  task automatic test_long_period();
    set_job(3, 255, 1);
    req = 4'b1000;
    for (int c = 0; c <= 258; c++) begin
      @(negedge clk);
      job_model(c, 3, 255, 1, -1, m_stat);
      if (c == 0) req = '0;
      checks++;
      if ({ack, done, busy, status, owner} !== {e_ack, e_done, e_busy, e_status, e_owner})
        $display("FAIL long_period c=%0d got %b exp %b", c, {ack, done, busy, status, owner},
                 {e_ack, e_done, e_busy, e_status, e_owner});
      else passes++;
    end
    m_stat = ~m_stat;
    m_last = 3;
  endtask

  task automatic test_abort_final();
    set_job(0, 1, 2);
    req = 4'b0001;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      job_model(c, 0, 1, 2, 3, m_stat);
      if (c == 0) req = '0;
      checks++;
      if ({ack, done, busy, status, owner} !== {e_ack, e_done, e_busy, e_status, e_owner})
        $display("FAIL abort_final c=%0d got %b exp %b", c, {ack, done, busy, status, owner},
                 {e_ack, e_done, e_busy, e_status, e_owner});
      else passes++;
      abort = (c == 3);
    end
    m_stat = 1'b0;
    m_last = 0;
  endtask

  task automatic test_async_reset();
    int idx;
    set_job(2, 3, 5);
    req = 4'b0100;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      job_model(c, 2, 3, 5, -1, m_stat);
      if (c == 0) req = '0;
      checks++;
      if ({ack, done, busy, status, owner} !== {e_ack, e_done, e_busy, e_status, e_owner})
        $display("FAIL async_pre c=%0d got %b exp %b", c, {ack, done, busy, status, owner},
                 {e_ack, e_done, e_busy, e_status, e_owner});
      else passes++;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ack, done, busy, status, owner} !== '0)
      $display("FAIL async_reset got %b exp 0", {ack, done, busy, status, owner});
    else passes++;
    @(negedge clk);
    m_stat = 1'b0;
    m_last = NREQ - 1;
    set_job(0, 0, 1);
    set_job(1, 0, 1);
    set_job(3, 0, 1);
    rst_n = 1'b1;
    req   = 4'b1011;
    idx   = rr_pick(m_last, 4'b1011);
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      job_model(c, idx, 0, 1, -1, m_stat);
      if (c == 0) req = '0;
      checks++;
      if ({ack, done, busy, status, owner} !== {e_ack, e_done, e_busy, e_status, e_owner})
        $display("FAIL async_post c=%0d got %b exp %b", c, {ack, done, busy, status, owner},
                 {e_ack, e_done, e_busy, e_status, e_owner});
      else passes++;
    end
    m_stat = 1'b1;
    m_last = idx;
  endtask

  task automatic test_random();
    int pr[NREQ];
    int nr[NREQ];
    logic [NREQ-1:0] mask;
    int idx, ab, last_c, done_c;
    for (int j = 0; j < 24; j++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        pr[i] = $urandom_range(0, 6);
        nr[i] = $urandom_range(0, 4);
        set_job(i, pr[i], nr[i]);
      end
      idx    = rr_pick(m_last, mask);
      done_c = (nr[idx] == 0) ? 1 : nr[idx] * (pr[idx] + 1);
      ab     = (nr[idx] > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, done_c - 1) : -1;
      last_c = (ab >= 0) ? ab + 1 : done_c + 1;
      req    = mask;
      for (int c = 0; c <= last_c; c++) begin
        @(negedge clk);
        job_model(c, idx, pr[idx], nr[idx], ab, m_stat);
        if (c == 0) req = '0;
        checks++;
        if ({ack, done, busy, status, owner} !== {e_ack, e_done, e_busy, e_status, e_owner})
          $display("FAIL random j=%0d c=%0d got %b exp %b", j, c, {ack, done, busy, status, owner},
                   {e_ack, e_done, e_busy, e_status, e_owner});
        else passes++;
        abort = (c == ab);
      end
      abort  = 1'b0;
      m_last = idx;
      m_stat = (ab >= 0) ? 1'b0 : (m_stat ^ nr[idx][0]);
    end
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_fairness();
    test_wrap();
    test_abort();
    test_zero_count();
    test_long_period();
    test_abort_final();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
